studio2_keypad: RTL and testbench
=================================

# studio2_keypad

Keypad front end for the Studio II core. Converts PS/2 key events into the state of two 10-key hex keypads, latches the keypad row selected by the CPU's `OUT 2` instruction, and drives the CDP1802 external flags EF3 (player A) and EF4 (player B). It sits between the PS/2 event stream and the CPU flag inputs, and replaces the ad-hoc key logic in the top level.

## Interface
Parameters:
- `HOLD_CYCLES`, default 1_000_000: minimum asserted time of a key after a press, in `clk_sys` cycles. Must be ≥1.
- `CW`, default `$clog2(HOLD_CYCLES+1)`: width of the hold counter. Derived; do not override.

Ports:
- `clk_sys`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ps2_key`  in  11  PS/2 event: [10] toggle strobe, [9] pressed, [8] extended, [7:0] scan code.
- `n_out`  in  3  CPU N lines.
- `mrd_n`  in  1  CPU memory-read strobe, active low.
- `tpb`  in  1  CPU timing pulse B.
- `bus_din`  in  8  CPU data bus, i.e. memory read data.
- `ef3_n`  out  1  EF3, active low; player A key selected by latch is held.
- `ef4_n`  out  1  EF4, active low; player B key selected by latch is held.
- `keylatch`  out  4  currently selected key (debug).
- `keys_a`, `keys_b`  out  10 each  effective key states (debug).

## Operation
- Reset values: `ef3_n`=`ef4_n`=1, `keylatch`=0, `keys_a`=`keys_b`=0, all counters 0, all pending flags 0, strobe/tpb history 0.
- PS/2 event: an event is detected when `ps2_key[10]` differs from its registered copy. Events with [8]=1 are ignored. Scan code map:
  - A0..A9: 45,16,1E,26,25,2E,36,3D,3E,46
  - B0..B9: 4D,15,1D,24,2D,2C,35,3C,43,44
  - Unmapped codes are ignored.
- Per-key cell, with registers `state`, `cnt[CW]`, `pend`:
  - Press: `state`←1, `cnt`←HOLD_CYCLES−1, `pend`←0. A typematic repeat press reloads `cnt`.
  - Release with `cnt`=0: `state`←0 immediately.
  - Release with `cnt`>0: `pend`←1, and `state` stays 1.
  - Each cycle with `cnt`>0: decrement `cnt`. When `cnt` reaches 0 with `pend`=1: `state`←0, `pend`←0.
  - A press while `pend`=1 cancels the release.
- Key latch: on the `tpb` rising edge (`tpb`=1, previous=0) with `n_out`=3'd2 and `mrd_n`=0 (OUT 2), `keylatch`←`bus_din[3:0]`. INP 2 (`mrd_n`=1) and other N values leave the latch unchanged. A `tpb` that stays high for several cycles latches once.
- Flags: `ef3_n` = ~`keys_a[keylatch]` and `ef4_n` = ~`keys_b[keylatch]` when `keylatch`≤9. When `keylatch` is 10–15, both flags are 1.
- Simultaneous events: a PS/2 event and an OUT 2 in the same cycle are both applied. A release and a counter expiry in the same cycle clear the key.

## Timing
- Key update: `state` changes on the first edge at which the toggle is seen, i.e. 1 cycle after `ps2_key` changes.
- `keylatch` updates on the edge where the `tpb` rise is seen.
- `ef3_n`/`ef4_n` are registered and change 1 cycle after `state` or `keylatch` changes.
- End-to-end latency: 2 cycles from `ps2_key` change or `tpb` rise to the flag output.
- Hold: a tap shorter than HOLD_CYCLES keeps the key asserted for exactly HOLD_CYCLES cycles after the press edge.
- Reset asserted mid-operation clears everything asynchronously. After release of reset, the first toggle comparison uses the reset history value 0.

## Structure
- `studio2_pkg` holds the scan-code constant arrays `KEY_A_CODES[10]` and `KEY_B_CODES[10]`, and `KEYPAD_PORT` = 3'd2.
- One sub-module, `studio2_key_cell`, implements the state/counter/pend logic for one key. The top instantiates 20 of them via generate.
- The top contains the PS/2 event decode, the `tpb` edge detect, the key latch, and the flag muxes.

## Test plan
Benches use HOLD_CYCLES=100.
1. Reset: hold `reset_n` low → `ef3_n`=`ef4_n`=1, `keylatch`=0, `keys_a`=`keys_b`=0. Then release reset with no activity → all outputs unchanged.
2. Press code 2E, then OUT 2 with `bus_din`=05 → `keys_a[5]`=1, and `ef3_n`=0 two cycles after the `tpb` rise; `ef4_n`=1.
3. Press code 2D, then OUT 2 with `bus_din`=04 → `ef4_n`=0, `ef3_n`=1. Release code 2D after 150 cycles → `ef4_n`=1 two cycles after the release.
4. Press 45, release after 10 cycles → `keys_a[0]` stays 1 until 100 cycles after the press, then 0. Re-press at cycle 50 instead → the release is cancelled and the key stays held.
5. With all keys pressed:
   - OUT 2 with `bus_din`=0C → both flags 1.
   - INP 2 (`mrd_n`=1) with `bus_din`=03 → `keylatch` stays C.
   - An event with code 45 and [8]=1 → no state change.
6. Press 3E, then assert `reset_n` low at cycle 40 of the hold → `keys_a`=0 and `ef3_n`=1 immediately, with no residual release after reset.

Source files
------------

// File: rtl/studio2_pkg.sv
// Studio II keypad shared constants: scan-code maps for the two
// hex keypads and the CPU port used to select a keypad row.
package studio2_pkg;

  localparam int NKEYS = 10;

  localparam logic [2:0] KEYPAD_PORT = 3'd2;

  localparam logic [7:0] KEY_A_CODES [NKEYS] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
    8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
  };

  localparam logic [7:0] KEY_B_CODES [NKEYS] = '{
    8'h4D, 8'h15, 8'h1D, 8'h24, 8'h2D,
    8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44
  };

endpackage

// File: rtl/studio2_key_cell.sv
// One keypad key: press/release with a minimum hold time.
// Ports: clk_sys, reset_n, key_dn/key_up (1-cycle pulses), state.
module studio2_key_cell #(
  parameter int HOLD_CYCLES = 1_000_000,
  parameter int CW = $clog2(HOLD_CYCLES + 1)
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic key_dn,
  input  logic key_up,
  output logic state
);

  localparam logic [CW-1:0] LOAD = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          pend;

  // A release during the hold window is parked in pend and takes
  // effect once the counter has run out, so a short tap is still
  // seen by the CPU for the full hold time.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= 1'b0;
      cnt   <= '0;
      pend  <= 1'b0;
    end else if (key_dn) begin
      state <= 1'b1;
      cnt   <= LOAD;
      pend  <= 1'b0;
    end else begin
      if (cnt != '0)
        cnt <= cnt - CW'(1);
      if (key_up && cnt == '0) begin
        state <= 1'b0;
        pend  <= 1'b0;
      end else if (key_up) begin
        pend <= 1'b1;
      end else if (pend && cnt == '0) begin
        state <= 1'b0;
        pend  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/studio2_keypad.sv
// PS/2 to Studio II keypad front end: key cells, OUT 2 row latch,
// registered EF3/EF4. Ports: clk_sys, reset_n, ps2_key, n_out, mrd_n,
// tpb, bus_din in; ef3_n, ef4_n, keylatch, keys_a, keys_b out.
module studio2_keypad
  import studio2_pkg::*;
#(
  parameter int HOLD_CYCLES = 1_000_000,
  parameter int CW = $clog2(HOLD_CYCLES + 1)
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [2:0]  n_out,
  input  logic        mrd_n,
  input  logic        tpb,
  input  logic [7:0]  bus_din,
  output logic        ef3_n,
  output logic        ef4_n,
  output logic [3:0]  keylatch,
  output logic [9:0]  keys_a,
  output logic [9:0]  keys_b
);

  logic strobe_q;
  logic tpb_q;
  logic ev;
  logic tpb_rise;
  logic [9:0] hit_a;
  logic [9:0] hit_b;
  logic [15:0] wide_a;
  logic [15:0] wide_b;
  logic unused;

  assign ev = (ps2_key[10] ^ strobe_q) & ~ps2_key[8];
  assign tpb_rise = tpb & ~tpb_q;
  assign unused = &{1'b0, bus_din[7:4]};

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    assign hit_a[i] = ev && ps2_key[7:0] == KEY_A_CODES[i];
    assign hit_b[i] = ev && ps2_key[7:0] == KEY_B_CODES[i];

    studio2_key_cell #(
      .HOLD_CYCLES(HOLD_CYCLES),
      .CW(CW)
    ) u_a (
      .clk_sys(clk_sys),
      .reset_n(reset_n),
      .key_dn(hit_a[i] & ps2_key[9]),
      .key_up(hit_a[i] & ~ps2_key[9]),
      .state(keys_a[i])
    );

    studio2_key_cell #(
      .HOLD_CYCLES(HOLD_CYCLES),
      .CW(CW)
    ) u_b (
      .clk_sys(clk_sys),
      .reset_n(reset_n),
      .key_dn(hit_b[i] & ps2_key[9]),
      .key_up(hit_b[i] & ~ps2_key[9]),
      .state(keys_b[i])
    );
  end

  // Zero-padded to 16 so latch values 10..15 read as released.
  assign wide_a = {6'b0, keys_a};
  assign wide_b = {6'b0, keys_b};

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q <= 1'b0;
      tpb_q    <= 1'b0;
      keylatch <= 4'd0;
      ef3_n    <= 1'b1;
      ef4_n    <= 1'b1;
    end else begin
      strobe_q <= ps2_key[10];
      tpb_q    <= tpb;
      if (tpb_rise && n_out == KEYPAD_PORT && !mrd_n)
        keylatch <= bus_din[3:0];
      ef3_n <= ~wide_a[keylatch];
      ef4_n <= ~wide_b[keylatch];
    end
  end

endmodule

// File: tb/tb_studio2_keypad.sv
// Bench for studio2_keypad: directed scenarios plus random traffic
// checked every cycle against a hold-time model of the keypads.
module tb_studio2_keypad;

  localparam int HOLD = 100;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] ps2_key = '0;
  logic [2:0]  n_out = '0;
  logic        mrd_n = 1'b1;
  logic        tpb = 1'b0;
  logic [7:0]  bus_din = '0;
  logic        ef3_n;
  logic        ef4_n;
  logic [3:0]  keylatch;
  logic [9:0]  keys_a;
  logic [9:0]  keys_b;

  studio2_keypad #(.HOLD_CYCLES(HOLD)) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .ps2_key(ps2_key),
    .n_out(n_out),
    .mrd_n(mrd_n),
    .tpb(tpb),
    .bus_din(bus_din),
    .ef3_n(ef3_n),
    .ef4_n(ef4_n),
    .keylatch(keylatch),
    .keys_a(keys_a),
    .keys_b(keys_b)
  );

  always #5 clk_sys = ~clk_sys;

  // 0..9 player A, 10..19 player B
  logic [7:0] codes [20] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
    8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
    8'h4D, 8'h15, 8'h1D, 8'h24, 8'h2D,
    8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44
  };

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit       phys [20];
  bit       pv [20];
  int       pedge [20];
  logic [3:0] m_latch;
  bit       m_hist;
  bit       m_tpb;
  logic     m_ef3;
  logic     m_ef4;

  task automatic check(string tag, logic [15:0] got,
                       logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // A key reads as pressed while physically held, or for HOLD
  // cycles after its most recent press edge.
  function automatic logic [19:0] m_keys();
    logic [19:0] k;
    for (int i = 0; i < 20; i++)
      k[i] = phys[i] || (pv[i] && (cyc - pedge[i] < HOLD));
    return k;
  endfunction

  function automatic logic flag(logic [9:0] k, logic [3:0] sel);
    logic [15:0] kk;
    kk = {6'b0, k};
    return ~kk[sel];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 20; i++) begin
      phys[i] = 0;
      pv[i] = 0;
      pedge[i] = 0;
    end
    m_latch = 4'd0;
    m_hist = 0;
    m_tpb = 0;
    m_ef3 = 1'b1;
    m_ef4 = 1'b1;
  endtask

  task automatic model_edge();
    logic [19:0] k;
    if (!reset_n) return;
    k = m_keys();
    m_ef3 = flag(k[9:0], m_latch);
    m_ef4 = flag(k[19:10], m_latch);
    cyc++;
    if (ps2_key[10] != m_hist && !ps2_key[8]) begin
      for (int i = 0; i < 20; i++) begin
        if (ps2_key[7:0] == codes[i]) begin
          if (ps2_key[9]) begin
            phys[i] = 1;
            pv[i] = 1;
            pedge[i] = cyc;
          end else begin
            phys[i] = 0;
          end
        end
      end
    end
    m_hist = ps2_key[10];
    if (tpb && !m_tpb && n_out == 3'd2 && !mrd_n)
      m_latch = bus_din[3:0];
    m_tpb = tpb;
  endtask

  task automatic compare();
    logic [19:0] k;
    k = m_keys();
    check("keys_a", 16'(keys_a), 16'(k[9:0]));
    check("keys_b", 16'(keys_b), 16'(k[19:10]));
    check("keylatch", 16'(keylatch), 16'(m_latch));
    check("ef3_n", 16'(ef3_n), 16'(m_ef3));
    check("ef4_n", 16'(ef4_n), 16'(m_ef4));
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_edge();
    @(negedge clk_sys);
    compare();
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic key(logic [7:0] code, bit pressed, bit ext = 0);
    ps2_key = {~ps2_key[10], pressed, ext, code};
    tick();
  endtask

  // tpb held high for three cycles; only the rise may latch
  task automatic out2(logic [7:0] d, bit mrd = 0,
                      logic [2:0] n = 3'd2);
    n_out = n;
    mrd_n = mrd;
    bus_din = d;
    tpb = 1'b1;
    idle(3);
    tpb = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1 compare();
    @(negedge clk_sys);
    idle(2);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] code;
    int r;
    model_reset();
    @(negedge clk_sys);
    compare();
    check("rst_ef3", 16'(ef3_n), 16'd1);
    check("rst_keys", 16'(keys_a | keys_b), 16'd0);
    idle(2);
    reset_n = 1'b1;
    idle(5);
    check("idle_latch", 16'(keylatch), 16'd0);

    key(8'h2E, 1);
    idle(3);
    out2(8'h05);
    check("t2_key5", 16'(keys_a[5]), 16'd1);
    check("t2_ef3", 16'(ef3_n), 16'd0);
    check("t2_ef4", 16'(ef4_n), 16'd1);

    key(8'h2D, 1);
    out2(8'h04);
    check("t3_ef4", 16'(ef4_n), 16'd0);
    check("t3_ef3", 16'(ef3_n), 16'd1);
    idle(150);
    key(8'h2D, 0);
    tick();
    check("t3_rel", 16'(ef4_n), 16'd1);
    key(8'h2E, 0);

    key(8'h45, 1);
    idle(9);
    key(8'h45, 0);
    idle(95);
    check("t4_expired", 16'(keys_a[0]), 16'd0);
    key(8'h45, 1);
    idle(9);
    key(8'h45, 0);
    idle(39);
    key(8'h45, 1);
    idle(120);
    check("t4_cancel", 16'(keys_a[0]), 16'd1);
    key(8'h45, 0);
    check("t4_rel", 16'(keys_a[0]), 16'd0);

    for (int i = 0; i < 20; i++) key(codes[i], 1);
    out2(8'h0C);
    check("t5_latchC", 16'(keylatch), 16'hC);
    check("t5_ef3", 16'(ef3_n), 16'd1);
    check("t5_ef4", 16'(ef4_n), 16'd1);
    out2(8'h03, 1);
    check("t5_inp2", 16'(keylatch), 16'hC);
    out2(8'h03, 0, 3'd3);
    check("t5_n3", 16'(keylatch), 16'hC);
    key(8'h45, 0, 1);
    check("t5_ext", 16'(keys_a[0]), 16'd1);
    out2(8'h09);
    for (int i = 0; i < 20; i++) key(codes[i], 0);
    idle(110);

    out2(8'h08);
    key(8'h3E, 1);
    idle(39);
    ps2_key = '0;
    do_reset();
    check("t6_keys", 16'(keys_a), 16'd0);
    check("t6_ef3", 16'(ef3_n), 16'd1);
    idle(120);

    repeat (3000) begin
      r = $urandom_range(0, 99);
      if (r < 12) begin
        if ($urandom_range(0, 9) == 0)
          code = 8'($urandom);
        else
          code = codes[$urandom_range(0, 19)];
        ps2_key = {~ps2_key[10], 1'($urandom),
                   ($urandom_range(0, 9) == 0), code};
      end else if (r < 18) begin
        tpb = ~tpb;
        if (tpb) begin
          n_out = ($urandom_range(0, 3) == 0) ?
                  3'($urandom) : 3'd2;
          mrd_n = ($urandom_range(0, 3) == 0);
          bus_din = {4'($urandom), 4'($urandom_range(0, 11))};
        end
      end else if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
